// File: rtl/seg_scan_driver.sv
// seg_scan_driver: six-digit multiplexed seven-segment scanner with tear-free shadow/active digit registers.
module seg_scan_driver #(
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] digit4,
    input  logic [3:0] digit5,
    input  logic [1:0] ampm,
    input  logic       load,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] dig_sel,
    output logic       frame_done
);
    localparam int            CW    = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CYC);
    localparam logic          INV   = (ACTIVE_LOW != 0);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [23:0]   sh_q, sh_d, act_q, act_d;
    logic          shpm_q, shpm_d, actpm_q, actpm_d;
    logic [6:0]    seg_q, seg_d, lit;
    logic          dp_q, dp_d, fd_q, fd_d, tick, wrap;
    logic [5:0]    dig_q, dig_d;
    logic [3:0]    cur;
    logic          unused_ampm;

    assign unused_ampm = ampm[1];

    always_comb begin
        tick    = (cnt_q == LAST);
        wrap    = tick && (idx_q == 3'd5);
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        idx_d   = wrap ? 3'd0 : tick ? idx_q + 3'd1 : idx_q;
        sh_d    = load ? {digit5, digit4, digit3, digit2, digit1, digit0} : sh_q;
        shpm_d  = load ? ampm[0] : shpm_q;
        // active takes the pre-edge shadow, so a load on the wrap edge shows one frame later
        act_d   = wrap ? sh_q : act_q;
        actpm_d = wrap ? shpm_q : actpm_q;
        cur     = act_q[{idx_q, 2'b00} +: 4];
        lit     = 7'h40;
        case (cur)
            4'd0: lit = 7'h3F;
            4'd1: lit = 7'h06;
            4'd2: lit = 7'h5B;
            4'd3: lit = 7'h4F;
            4'd4: lit = 7'h66;
            4'd5: lit = 7'h6D;
            4'd6: lit = 7'h7D;
            4'd7: lit = 7'h07;
            4'd8: lit = 7'h7F;
            4'd9: lit = 7'h6F;
            4'hF: lit = 7'h00;
            default: lit = 7'h40;
        endcase
        seg_d   = lit ^ {7{INV}};
        dp_d    = ((idx_q == 3'd2) || (idx_q == 3'd4) || ((idx_q == 3'd0) && actpm_q)) ^ INV;
        dig_d   = ((cnt_q >= BLANK) ? (6'b1 << idx_q) : 6'b0) ^ {6{INV}};
        fd_d    = wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '1;
            act_q   <= '1;
            shpm_q  <= 1'b0;
            actpm_q <= 1'b0;
            seg_q   <= {7{INV}};
            dp_q    <= INV;
            dig_q   <= {6{INV}};
            fd_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            act_q   <= act_d;
            shpm_q  <= shpm_d;
            actpm_q <= actpm_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            dig_q   <= dig_d;
            fd_q    <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign dig_sel    = dig_q;
    assign frame_done = fd_q;
endmodule
